mfcc_frame_sched: RTL and testbench

Per-frame controller for the MFCC feature path. It accepts a frame-ready indication from the framing buffer and launches the MFCC and log-energy pipelines. It then collects the 13 cepstral coefficients and the log energy, substitutes the energy for coefficient 0, and streams the 13-word vector to the VAD classifier with backpressure. It also enforces a startup hold-off and a per-frame completion timeout.

---
 rtl/mfcc_frame_sched.sv | 141 ++++++++++++++
 tb/tb_mfcc_frame_sched.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mfcc_frame_sched.sv
// Per-frame MFCC scheduler: acks frames, gathers 13 coefficients plus log energy, streams the vector out.
// Optional completion timeout enabled by defining MFCC_SCHED_TIMEOUT_EN.
module mfcc_frame_sched #(
  parameter int NUM_COEF    = 13,
  parameter int DATA_W      = 32,
  parameter int STARTUP_CYC = 255,
  parameter int TIMEOUT_CYC = 4095
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_ready,
  output logic              frame_ack,
  output logic              mfcc_start,
  output logic              energy_start,
  input  logic              tvalid_mfcc_feat,
  input  logic [DATA_W-1:0] mfcc_feat,
  input  logic              tvalid_log_energy,
  input  logic [DATA_W-1:0] log_energy,
  output logic              out_tvalid,
  input  logic              out_tready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              err_timeout,
  output logic [15:0]       frame_cnt,
  output logic [1:0]        dbg_state
);

  localparam int IDX_W = $clog2(NUM_COEF + 1);
  localparam int SU_W  = $clog2(STARTUP_CYC + 1);
  localparam logic [IDX_W-1:0] FULL = IDX_W'(NUM_COEF);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_COEF - 1);

  typedef enum logic [1:0] {S_STARTUP, S_IDLE, S_COLLECT, S_EMIT} state_t;

  state_t            state, nxt;
  logic [SU_W-1:0]   su_cnt;
  logic [IDX_W-1:0]  idx, k;
  logic [DATA_W-1:0] coef [NUM_COEF];
  logic [DATA_W-1:0] energy_reg;
  logic              energy_flag, e_prev, ack_q, err_q;
  logic              accept, energy_edge, complete, out_fire, timed_out;

  assign accept      = (state == S_IDLE) && frame_ready;
  assign energy_edge = tvalid_log_energy && !e_prev;
  assign complete    = (idx == FULL) && energy_flag;

  // Output stream: a beat moves on any cycle where out_tvalid && out_tready;
  // while out_tready is low the beat index k holds, so data and last hold too.
  assign out_tvalid = (state == S_EMIT);
  assign out_fire   = out_tvalid && out_tready;
  assign out_data   = !out_tvalid ? '0 : (k == '0) ? energy_reg : coef[k];
  assign out_last   = out_tvalid && (k == LAST);

  assign frame_ack    = ack_q;
  assign mfcc_start   = ack_q;
  assign energy_start = ack_q;
  assign err_timeout  = err_q;
  assign busy         = (state != S_IDLE);
  assign dbg_state    = state;

`ifdef MFCC_SCHED_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt;

  always_ff @(posedge clk) begin
    if (rst || state != S_COLLECT) to_cnt <= '0;
    else                           to_cnt <= to_cnt + TO_W'(1);
  end

  // Completion wins over an expiry landing in the same cycle.
  assign timed_out = (state == S_COLLECT) && !complete && (to_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
  // Never true: without the timeout the frame waits indefinitely.
  assign timed_out = (TIMEOUT_CYC < 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_STARTUP;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_STARTUP: if (su_cnt == SU_W'(STARTUP_CYC - 1)) nxt = S_IDLE;
      S_IDLE:    if (frame_ready) nxt = S_COLLECT;
      S_COLLECT: begin
        if (complete)       nxt = S_EMIT;
        else if (timed_out) nxt = S_IDLE;
      end
      S_EMIT:    if (out_fire && k == LAST) nxt = S_IDLE;
      default:   nxt = S_STARTUP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      e_prev      <= 1'b0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      su_cnt      <= '0;
      idx         <= '0;
      k           <= '0;
      energy_reg  <= '0;
      energy_flag <= 1'b0;
      frame_cnt   <= '0;
      for (int i = 0; i < NUM_COEF; i++) coef[i] <= '0;
    end else begin
      e_prev <= tvalid_log_energy;
      ack_q  <= accept;
      err_q  <= timed_out;
      su_cnt <= (state == S_STARTUP) ? su_cnt + SU_W'(1) : '0;
      if (accept) begin
        idx         <= '0;
        k           <= '0;
        energy_flag <= 1'b0;
      end
      // Coefficient beat and energy edge in one cycle are both taken.
      if (state == S_COLLECT) begin
        if (tvalid_mfcc_feat && idx < FULL) begin
          coef[idx] <= mfcc_feat;
          idx       <= idx + IDX_W'(1);
        end
        if (energy_edge) begin
          energy_reg  <= log_energy;
          energy_flag <= 1'b1;
        end
      end
      if (out_fire) begin
        if (k == LAST) begin
          k         <= '0;
          frame_cnt <= frame_cnt + 16'd1;
        end else begin
          k <= k + IDX_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mfcc_frame_sched.sv
// Bench for mfcc_frame_sched: frame-level reference queue checked against the output stream every cycle.
module tb_mfcc_frame_sched;
  localparam int NC = 13;
  localparam int DW = 32;
  localparam int TO = 100;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          frame_ready = 1'b0;
  logic          frame_ack, mfcc_start, energy_start;
  logic          tvalid_mfcc_feat = 1'b0;
  logic [DW-1:0] mfcc_feat = '0;
  logic          tvalid_log_energy = 1'b0;
  logic [DW-1:0] log_energy = '0;
  logic          out_tvalid;
  logic          out_tready = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_last, busy, err_timeout;
  logic [15:0]   frame_cnt;
  logic [1:0]    dbg_state;

  mfcc_frame_sched #(.NUM_COEF(NC), .DATA_W(DW), .STARTUP_CYC(255), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .frame_ready(frame_ready), .frame_ack(frame_ack),
    .mfcc_start(mfcc_start), .energy_start(energy_start),
    .tvalid_mfcc_feat(tvalid_mfcc_feat), .mfcc_feat(mfcc_feat),
    .tvalid_log_energy(tvalid_log_energy), .log_energy(log_energy),
    .out_tvalid(out_tvalid), .out_tready(out_tready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .err_timeout(err_timeout), .frame_cnt(frame_cnt), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int            n_cmp = 0, n_bad = 0;
  int            cyc = 0;
  int            rmode = 0, ph = 0;
  int            beat_i = 0;
  int            nf = 0;
  bit            to_window = 1'b0;
  logic          prev_ack = 1'b0;
  logic [15:0]   model_cnt = '0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] cap[$];
  logic [DW-1:0] fr_coef[NC];
  logic [DW-1:0] fr_energy;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Downstream ready: 0 = always, 1 = pattern 1,0,0,1, 2 = random
  initial forever begin
    @(posedge clk);
    #1;
    case (rmode)
      0:       out_tready = 1'b1;
      1:       out_tready = (ph % 4 == 0) || (ph % 4 == 3);
      default: out_tready = 1'($urandom_range(0, 1));
    endcase
    ph++;
  end

  // Scoreboard: every expected beat is queued at frame acceptance, in order.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      exp_q.delete();
      model_cnt = '0;
      beat_i    = 0;
      prev_ack  = 1'b0;
    end else begin
      chk("frame_cnt", 32'(frame_cnt), 32'(model_cnt));
      if (!to_window) chk("err_timeout", 32'(err_timeout), 32'd0);
      if (frame_ack) begin
        chk("ack_width", 32'(prev_ack), 32'd0);
        chk("start_sync", {30'd0, mfcc_start, energy_start}, 32'd3);
      end
      prev_ack = frame_ack;
      if (out_tvalid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 32'(out_tvalid), 32'd0);
        end else begin
          chk("out_data", out_data, exp_q[0]);
          chk("out_last", 32'(out_last), 32'(beat_i == NC - 1));
          if (out_tready) begin
            cap.push_back(out_data);
            void'(exp_q.pop_front());
            if (beat_i == NC - 1) begin
              beat_i = 0;
              model_cnt++;
            end else begin
              beat_i++;
            end
          end
        end
      end else begin
        chk("idle_data", out_data, '0);
        chk("idle_last", 32'(out_last), 32'd0);
      end
    end
  end

  task automatic get_ack(output bit ok);
    int w;
    w = 0;
    frame_ready = 1'b1;
    do begin
      step();
      w++;
    end while (!frame_ack && w < 600);
    ok = frame_ack;
    if (!ok) chk("ack_wait", 32'(frame_ack), 32'd1);
    frame_ready = 1'b0;
  endtask

  // epos: 0 energy before coefs, 1 after coefs, 2 decoy first then real edge on a coef cycle.
  // gap < 0 gives random idle cycles between coefficient beats.
  task automatic send_frame(input int epos, input int gap, input int extra, input bit handshake);
    bit ok;
    int j, g;
    ok = 1'b1;
    if (handshake) begin
      tvalid_log_energy = 1'b1;
      log_energy = 32'hDEAD_BEEF;
      step();
      tvalid_log_energy = 1'b0;
      log_energy = '0;
      step();
      get_ack(ok);
    end
    if (!ok) return;
    exp_q.push_back(fr_energy);
    for (int i = 1; i < NC; i++) exp_q.push_back(fr_coef[i]);
    j = (epos == 2) ? $urandom_range(0, NC - 1) : -1;
    if (epos != 1) begin
      tvalid_log_energy = 1'b1;
      log_energy = (epos == 0) ? fr_energy : $urandom;
      step();
      tvalid_log_energy = 1'b0;
      log_energy = '0;
      if (epos == 2) step();
    end
    for (int i = 0; i < NC + extra; i++) begin
      tvalid_mfcc_feat = 1'b1;
      mfcc_feat = (i < NC) ? fr_coef[i] : $urandom;
      if (i == j) begin
        tvalid_log_energy = 1'b1;
        log_energy = fr_energy;
      end
      step();
      tvalid_mfcc_feat = 1'b0;
      mfcc_feat = '0;
      tvalid_log_energy = 1'b0;
      log_energy = '0;
      g = (gap < 0) ? $urandom_range(0, 3) : gap;
      repeat (g) step();
    end
    if (epos == 1) begin
      repeat ($urandom_range(0, 3)) step();
      tvalid_log_energy = 1'b1;
      log_energy = fr_energy;
      step();
      tvalid_log_energy = 1'b0;
      log_energy = '0;
    end
    repeat (3) step();
  endtask

  task automatic wait_frames(input int n);
    for (int i = 0; i < 3000 && !(int'(model_cnt) == n && exp_q.size() == 0); i++) @(posedge clk);
    @(negedge clk);
    chk("drain_model", 32'(model_cnt), 32'(n));
    chk("drain_frame_cnt", 32'(frame_cnt), 32'(n));
  endtask

  task automatic chk_ref_frame(input string tag);
    chk({tag, "_beats"}, 32'(cap.size()), 32'd13);
    chk({tag, "_beat0"}, cap[0], 32'h4120_0000);
    chk({tag, "_beat1"}, cap[1], 32'h3F80_0001);
    chk({tag, "_beat12"}, cap[12], 32'h3F80_000C);
  endtask

  task automatic startup_check(input string tag, input bit raise_ready);
    int busy_n, early_ack;
    busy_n = 0;
    early_ack = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (raise_ready && i == 10) frame_ready = 1'b1;
      if (frame_ack) early_ack++;
      if (busy) busy_n++;
      else break;
    end
    chk({tag, "_busy_cycles"}, 32'(busy_n), 32'd255);
    chk({tag, "_no_early_ack"}, 32'(early_ack), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation stuck at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NC; i++) fr_coef[i] = 32'h3F80_0000 + DW'(i);
    fr_energy = 32'h4120_0000;

    // Startup hold-off, frame_ready raised early
    do_reset();
    startup_check("startup", 1'b1);
    @(posedge clk);
    #1;
    chk("ack_after_idle", 32'(frame_ack), 32'd1);
    chk("mfcc_start_first", 32'(mfcc_start), 32'd1);
    chk("energy_start_first", 32'(energy_start), 32'd1);
    frame_ready = 1'b0;

    // Back-to-back coefficients, energy afterwards
    rmode = 0;
    cap.delete();
    send_frame(1, 0, 0, 1'b0);
    nf = 1;
    wait_frames(nf);
    chk_ref_frame("f1");
    chk("f1_frame_cnt", 32'(frame_cnt), 32'd1);

    // Energy first, sparse beats, two extra beats dropped
    cap.delete();
    send_frame(0, 2, 2, 1'b1);
    nf = 2;
    wait_frames(nf);
    chk_ref_frame("f2");

    // Stalling downstream 1,0,0,1 with overwritten energy
    rmode = 1;
    cap.delete();
    send_frame(2, 0, 0, 1'b1);
    nf = 3;
    wait_frames(nf);
    chk_ref_frame("f3");

    // Randomized frames and backpressure
    rmode = 2;
    for (int f = 0; f < 20; f++) begin
      for (int i = 0; i < NC; i++) fr_coef[i] = $urandom;
      fr_energy = $urandom;
      send_frame($urandom_range(0, 2), ($urandom_range(0, 1) != 0) ? -1 : $urandom_range(0, 3),
                 $urandom_range(0, 2), 1'b1);
      nf++;
    end
    wait_frames(nf);

`ifdef MFCC_SCHED_TIMEOUT_EN
    begin
      bit ok;
      int t0, lat;
      get_ack(ok);
      t0 = cyc;
      to_window = 1'b1;
      for (int i = 0; i < 5; i++) begin
        tvalid_mfcc_feat = 1'b1;
        mfcc_feat = $urandom;
        step();
        tvalid_mfcc_feat = 1'b0;
        step();
      end
      lat = -1;
      for (int i = 0; i < 300; i++) begin
        if (err_timeout) begin
          lat = cyc - t0;
          break;
        end
        step();
      end
      chk("timeout_latency", 32'(lat >= TO - 1 && lat <= TO + 1), 32'd1);
      step();
      chk("timeout_width", 32'(err_timeout), 32'd0);
      chk("timeout_idle", 32'(busy), 32'd0);
      to_window = 1'b0;
      for (int i = 0; i < NC; i++) fr_coef[i] = $urandom;
      fr_energy = $urandom;
      send_frame(1, 1, 0, 1'b1);
      nf++;
      wait_frames(nf);
    end
`endif

    // Reset on the sixth beat of an emit
    rmode = 1;
    cap.delete();
    for (int i = 0; i < NC; i++) fr_coef[i] = $urandom;
    fr_energy = $urandom;
    send_frame(1, 0, 0, 1'b1);
    for (int i = 0; i < 500; i++) begin
      if (out_tvalid && cap.size() == 5) break;
      step();
    end
    chk("rst_at_beat6", 32'(cap.size()), 32'd5);
    rst = 1'b1;
    step();
    chk("rst_tvalid", 32'(out_tvalid), 32'd0);
    chk("rst_data", out_data, '0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_ack", 32'(frame_ack), 32'd0);
    chk("rst_err", 32'(err_timeout), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    @(negedge clk);
    step();
    rst = 1'b0;
    startup_check("restart", 1'b0);

    // Recovery frame after the abort
    rmode = 2;
    for (int i = 0; i < NC; i++) fr_coef[i] = $urandom;
    fr_energy = $urandom;
    send_frame(2, -1, 1, 1'b1);
    wait_frames(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
